// File: rtl/mul_repadd_seq.sv
`default_nettype none
// ============================================================================
// Module   : mul_repadd_seq
// Purpose  : Sequential unsigned multiplier by repeated addition; operands
//            loaded serially on data_in, one addition per clock.
//            Optional operand swap (n = min(A,B)) under MUL_OPERAND_SWAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mul_repadd_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               eqz
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_ADD    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] c_one   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_zeros = '0;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] p_q, p_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD_A;
            end
            S_LOAD_A: begin
                a_d     = data_in;
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                b_d     = data_in;
                p_d     = '0;
                state_d = S_ADD;
`ifdef MUL_OPERAND_SWAP_EN
                // Keep the smaller operand as the iteration count.
                if (data_in > a_q) begin
                    a_d = data_in;
                    b_d = a_q;
                end
`endif
            end
            S_ADD: begin
                if (b_q != c_zeros) begin
                    p_d = p_q + {c_zeros, a_q};
                    b_d = b_q - c_one;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign product = p_q;
    assign eqz     = (b_q == c_zeros);

endmodule
`default_nettype wire

// File: tb/tb_mul_repadd_seq.sv
`default_nettype none
// Testbench for mul_repadd_seq: directed operations with a queue of expected
// products/latencies, checked when done is observed.
module tb_mul_repadd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] data_in;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        eqz;

    logic        start8;
    logic [7:0]  din8;
    logic        busy8;
    logic        done8;
    logic [15:0] product8;
    logic        eqz8;

    mul_repadd_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .busy(busy), .done(done), .product(product), .eqz(eqz)
    );

    mul_repadd_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .data_in(din8),
        .busy(busy8), .done(done8), .product(product8), .eqz(eqz8)
    );

    typedef struct {
        logic [31:0] prod;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int n_of(input logic [15:0] a, input logic [15:0] b);
`ifdef MUL_OPERAND_SWAP_EN
        return int'((b > a) ? a : b);
`else
        return int'(b);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.prod = 32'(a) * 32'(b);
        e.lat  = n_of(a, b) + 3;
        sb.push_back(e);
    endtask

    // Entered at a negedge in IDLE; leaves at the negedge after the LOAD_B edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        push(a, b);
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start   = 1'b0;
        data_in = a;
        @(posedge clk); @(negedge clk);
        data_in = b;
        @(posedge clk); @(negedge clk);
        data_in = 16'($urandom);
    endtask

    // cyc counts edges since the start edge; starts at 2 after issue().
    task automatic wait_done(input bit pulse, output int c);
        c = 2;
        while (!done && c < 300) begin
            if (pulse) start = (c == 3);
            @(posedge clk); @(negedge clk);
            c++;
        end
        if (c >= 300) chk("done_timeout", 32'(c), 32'd0);
        if (pulse) start = 1'b1;
    endtask

    task automatic finish_op(input string tag, input int c);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_product"}, product, e.prod);
        chk({tag, "_latency"}, 32'(c), 32'(e.lat));
        chk({tag, "_eqz_done"}, 32'(eqz), 32'd1);
        chk({tag, "_busy_done"}, 32'(busy), 32'd1);
        @(posedge clk); @(negedge clk);
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_hold"}, product, e.prod);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; data_in = '0;
        start8 = 1'b0; din8 = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_product", product, 32'd0);
        chk("rst_eqz", 32'(eqz), 32'd1);

        issue(16'd17, 16'd5);  wait_done(1'b0, cyc); finish_op("m17x5", cyc);
        issue(16'd5, 16'd17);  wait_done(1'b0, cyc); finish_op("m5x17", cyc);
        issue(16'd0, 16'd9);   wait_done(1'b0, cyc); finish_op("m0x9", cyc);
        issue(16'd9, 16'd0);   wait_done(1'b0, cyc); finish_op("m9x0", cyc);

        // start pulsed during ADD and during DONE must be ignored
        issue(16'd17, 16'd5);  wait_done(1'b1, cyc); finish_op("pulse", cyc);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("pulse_no_restart", 32'(busy), 32'd0);

        // start held high: back-to-back with one IDLE cycle between
        push(16'd3, 16'd4); push(16'd6, 16'd7);
        start = 1'b1;
        @(posedge clk); @(negedge clk); data_in = 16'd3;
        @(posedge clk); @(negedge clk); data_in = 16'd4;
        @(posedge clk); @(negedge clk);
        wait_done(1'b0, cyc); finish_op("held1", cyc);
        @(posedge clk); @(negedge clk);
        chk("held_restart", 32'(busy), 32'd1);
        data_in = 16'd6;
        @(posedge clk); @(negedge clk); data_in = 16'd7; start = 1'b0;
        @(posedge clk); @(negedge clk);
        wait_done(1'b0, cyc); finish_op("held2", cyc);

        // reset mid-ADD, then a fresh operation
        issue(16'd17, 16'd5);
        @(posedge clk); @(negedge clk);
        chk("midadd_product", product, 32'd17);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_product", product, 32'd0);
        chk("midrst_eqz", 32'(eqz), 32'd1);
        issue(16'd3, 16'd4);   wait_done(1'b0, cyc); finish_op("m3x4", cyc);

        // 8-bit instance: maximum operands, no overflow
        start8 = 1'b1;
        @(posedge clk); @(negedge clk); start8 = 1'b0; din8 = 8'd255;
        @(posedge clk); @(negedge clk); din8 = 8'd255;
        @(posedge clk); @(negedge clk); din8 = 8'd0;
        cyc = 2;
        while (!done8 && cyc < 400) begin
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        chk("w8_product", 32'(product8), 32'd65025);
        chk("w8_latency", 32'(cyc), 32'd258);
        chk("w8_eqz", 32'(eqz8), 32'd1);
        chk("w8_busy", 32'(busy8), 32'd1);
        @(posedge clk); @(negedge clk);
        chk("w8_idle", 32'(busy8), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_repadd_seq.md
# mul_repadd_seq

Parametrised sequential multiplier using repeated addition: two unsigned WIDTH-bit operands are loaded serially over a shared `data_in` bus, and the product accumulates one addition per clock. It is the next generation of the team's fixed 16-bit datapath/controller multiplier, folded into one block. It adds a synchronous reset, busy/done handshake, a full-width 2*WIDTH product, zero-operand early exit, and an optional operand swap that minimises the iteration count.

## Interface
- `WIDTH`, 16, operand width in bits (≥2)
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  begin an operation; sampled only in IDLE
- `data_in`  input  WIDTH  operand bus: A on the first load edge, B on the second
- `busy`  output  1  high in every state except IDLE
- `done`  output  1  one-cycle completion pulse
- `product`  output  2*WIDTH  result; valid from the `done` cycle until the next operation's LOAD_B edge
- `eqz`  output  1  high when the iteration counter B == 0 (status/debug)

## Operation
- Internal registers:
  - `a` (WIDTH): addend
  - `b` (WIDTH): iteration counter
  - `p` (2*WIDTH): accumulator, drives `product`
- States: IDLE, LOAD_A, LOAD_B, ADD, DONE (Moore outputs).
- IDLE → LOAD_A when `start`=1 at an edge; otherwise stay.
- LOAD_A: at the edge, `a` <= `data_in`; → LOAD_B.
- LOAD_B: at the edge, `b` <= `data_in` and `p` <= 0; → ADD. The operand swap (see Configuration) also happens at this edge.
- ADD, when `b` != 0: `p` <= `p` + zero-extended `a`, `b` <= `b` − 1; stay in ADD.
- ADD, when `b` == 0: no add; → DONE.
- DONE: `done`=1; → IDLE unconditionally.
- Arithmetic:
  - Unsigned only.
  - `p` is 2*WIDTH bits and cannot overflow, because (2^W−1)² < 2^(2W).
  - `b` never decrements below 0.
- Boundary conditions:
  - `start` is ignored in LOAD_A, LOAD_B, ADD and DONE. No queuing.
  - `start` held high continuously: a new operation begins in the IDLE cycle after DONE.
  - A zero operand gives product 0, with iteration count as defined under Configuration.
  - `data_in` is don't-care outside the LOAD_A and LOAD_B edges.
- Reset, at any state including mid-ADD, takes effect at the next edge and forces:
  - state = IDLE
  - `a`, `b`, `p` = 0
  - `busy`=0, `done`=0, `product`=0, `eqz`=1

## Timing
- Edge numbering: `start` is sampled at edge k.
  - Edge k+1 loads A.
  - Edge k+2 loads B.
  - Edges k+3 … k+2+n perform the n additions.
  - Edge k+3+n enters DONE.
  - Edge k+4+n returns to IDLE.
- `done` is high for exactly the one cycle between edges k+3+n and k+4+n.
- Latency from `start` edge to `done` asserted is n+3 clocks, where n = effective B.
- `busy` rises after edge k and falls after edge k+4+n.
- `product` increments each ADD cycle and is final when `done`=1.
- `product` holds until the LOAD_B edge of the next operation.

## Configuration
- Macro: `MUL_OPERAND_SWAP_EN`.
- Defined: at the LOAD_B edge, if `data_in` > `a`, then `a` <= `data_in` and `b` <= old `a`. Otherwise load as normal. No extra cycle is added.
  - Effect: n = min(A,B).
- Undefined: no compare and no swap.
  - Effect: n = B, the second operand, always.
- The product value is identical in both builds. Only the ADD-cycle count and `done` timing differ.

## Test plan
- WIDTH=16, `start` then `data_in`=17, 5:
  - `product`=85.
  - `done` at start edge +8 in both builds (n=5).
- WIDTH=16, `data_in`=5, 17:
  - `product`=85.
  - With swap: `done` at +8 (n=5).
  - Without swap: `done` at +20 (n=17).
- Zero operands:
  - A=0, B=9: `product`=0. With swap n=0, `done` at +3. Without swap n=9, `done` at +12.
  - A=9, B=0: `product`=0, n=0 in both builds.
- WIDTH=8, A=255, B=255: `product`=65025, n=255, no overflow. `eqz`=1 at DONE.
- Handshake:
  - `start` pulsed during ADD and during DONE: ignored, and the result is unchanged.
  - `start` held high: back-to-back operations separated by one IDLE cycle.
- `rst`=1 for one edge mid-ADD of 17×5:
  - Next cycle: state IDLE, `busy`=0, `done`=0, `product`=0.
  - A fresh 3×4 operation afterwards yields 12.
